// File: rtl/instr_issue.sv
// Program-buffer issue unit: feeds one registered instruction per clock to the core, NOP fill otherwise.
// Latency: first word one edge after start; stall/redirect each cost exactly one NOP cycle, no words lost.
// Optional jump support enabled by defining INSTR_ISSUE_REDIRECT_EN (redirect ports ignored otherwise).
module instr_issue #(
  parameter int          DEPTH = 64,
  parameter int          AW    = 6,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   instruction,
  output logic [31:0]   pc,
  output logic          valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  state_t        state, state_n;
  logic [AW:0]   idx, idx_n, len, len_n, len_clamped;
  logic [31:0]   instr_n, pc_n;
  logic          valid_n;
  logic [31:0]   mem [DEPTH];
  logic          redir_hit, redir_ok;
  logic [AW-1:0] redir_idx;
  logic          unused_in;

  assign unused_in   = ^{redirect, redirect_pc};
  assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

`ifdef INSTR_ISSUE_REDIRECT_EN
  assign redir_idx = redirect_pc[AW+1:2];
  assign redir_hit = redirect;
  assign redir_ok  = ({1'b0, redir_idx} < len);
`else
  assign redir_idx = '0;
  assign redir_hit = 1'b0;
  assign redir_ok  = 1'b0;
`endif

  // Loads are only legal outside RUN, and a simultaneous start drops them.
  always_ff @(posedge clock) begin
    if (load_en && (state != RUN) && !start)
      mem[load_addr] <= load_data;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len;
    instr_n = NOP;
    pc_n    = pc;
    valid_n = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (prog_len == '0) begin
            state_n = DONE;
          end else begin
            len_n   = len_clamped;
            instr_n = mem[0];
            pc_n    = '0;
            valid_n = 1'b1;
            idx_n   = ONE;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (redir_hit) begin
          if (redir_ok) idx_n = {1'b0, redir_idx};
          else          state_n = DONE;
        end else if (stall) begin
          // bubble: idx and pc hold so the pending word is issued next
        end else if (idx == len) begin
          state_n = DONE;
        end else begin
          instr_n = mem[idx[AW-1:0]];
          pc_n    = {{(32-AW-3){1'b0}}, idx, 2'b00};
          valid_n = 1'b1;
          idx_n   = idx + ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      len         <= '0;
      instruction <= NOP;
      pc          <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      len         <= len_n;
      instruction <= instr_n;
      pc          <= pc_n;
      valid       <= valid_n;
      busy        <= (state_n == RUN);
      done        <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: directed stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_instr_issue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset, load_en, start, stall, redirect;
  logic [5:0]  load_addr;
  logic [31:0] load_data, redirect_pc;
  logic [6:0]  prog_len;
  logic [31:0] instruction, pc;
  logic        valid, busy, done;

  always #5 clock = ~clock;

  instr_issue dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instruction(instruction),
    .pc(pc), .valid(valid), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        busy;
    logic        done;
    bit          chk_pc;
    int          id;
  } exp_t;

  exp_t        q[$];
  int          passed = 0;
  int          total  = 0;
  int          next_id = 0;
  logic [31:0] w [8];

  // addi a1..a5 / x16..x18, zero, k
  initial begin
    w[0] = 32'h00100593; w[1] = 32'h00200613; w[2] = 32'h00300693; w[3] = 32'h00400713;
    w[4] = 32'h00500793; w[5] = 32'h00600813; w[6] = 32'h00700893; w[7] = 32'h00800913;
  end

  task automatic step(input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                       input logic eb, input logic ed, input bit cp);
    exp_t e;
    @(posedge clock);
    #1;
    e.instr = ei; e.pc = ep; e.valid = ev; e.busy = eb; e.done = ed; e.chk_pc = cp;
    e.id = next_id;
    next_id++;
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (instruction === e.instr && valid === e.valid && busy === e.busy &&
          done === e.done && (!e.chk_pc || pc === e.pc))
        passed++;
      else
        $display("FAIL out#%0d: got instr=%h pc=%h valid=%b busy=%b done=%b, want instr=%h pc=%h(chk=%0d) valid=%b busy=%b done=%b",
                 e.id, instruction, pc, valid, busy, done, e.instr, e.pc, e.chk_pc, e.valid, e.busy, e.done);
    end
  end

  initial begin
    reset = 1'b1; load_en = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    load_addr = '0; load_data = '0; redirect_pc = '0; prog_len = '0;

    // reset state
    step(NOP, 0, 0, 0, 0, 1);
    step(NOP, 0, 0, 0, 0, 1);
    reset = 1'b0;

    // load program, IDLE outputs unaffected
    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1; load_addr = 6'(i); load_data = w[i];
      step(NOP, 0, 0, 0, 0, 1);
    end
    load_en = 1'b0;

    // plain run of 5 words
    prog_len = 7'd5; start = 1'b1;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0;
    for (int i = 1; i < 5; i++) step(w[i], 32'(4*i), 1, 1, 0, 1);
    step(NOP, 0, 0, 0, 1, 0);
    step(NOP, 0, 0, 0, 1, 0);

    // two stall cycles after the 2nd word
    start = 1'b1;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0;
    step(w[1], 4, 1, 1, 0, 1);
    stall = 1'b1;
    step(NOP, 4, 0, 1, 0, 1);
    step(NOP, 4, 0, 1, 0, 1);
    stall = 1'b0;
    step(w[2], 8, 1, 1, 0, 1);
    step(w[3], 12, 1, 1, 0, 1);
    step(w[4], 16, 1, 1, 0, 1);
    step(NOP, 0, 0, 0, 1, 0);

    // zero-length program
    prog_len = 7'd0; start = 1'b1;
    step(NOP, 0, 0, 0, 1, 0);
    start = 1'b0;
    step(NOP, 0, 0, 0, 1, 0);

    // load during RUN is ignored; start during RUN is ignored
    prog_len = 7'd3; start = 1'b1;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0; load_en = 1'b1; load_addr = 6'd0; load_data = 32'hDEADBEEF;
    step(w[1], 4, 1, 1, 0, 1);
    load_en = 1'b0; start = 1'b1; prog_len = 7'd5;
    step(w[2], 8, 1, 1, 0, 1);
    start = 1'b0;
    step(NOP, 0, 0, 0, 1, 0);
    prog_len = 7'd1; start = 1'b1;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0;
    step(NOP, 0, 0, 0, 1, 0);

    // start and load together from DONE: load dropped
    prog_len = 7'd1; start = 1'b1; load_en = 1'b1; load_addr = 6'd0; load_data = 32'hCAFEF00D;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0; load_en = 1'b0;
    step(NOP, 0, 0, 0, 1, 0);
    start = 1'b1;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0;
    step(NOP, 0, 0, 0, 1, 0);

    // reset during the 3rd word
    prog_len = 7'd5; start = 1'b1;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0;
    step(w[1], 4, 1, 1, 0, 1);
    step(w[2], 8, 1, 1, 0, 1);
    reset = 1'b1;
    step(NOP, 0, 0, 0, 0, 1);
    reset = 1'b0;
    step(NOP, 0, 0, 0, 0, 1);

`ifdef INSTR_ISSUE_REDIRECT_EN
    // in-range redirect: one bubble then buf[6], buf[7]
    prog_len = 7'd8; start = 1'b1;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0; redirect = 1'b1; redirect_pc = 32'd24;
    step(NOP, 0, 0, 1, 0, 0);
    redirect = 1'b0;
    step(w[6], 24, 1, 1, 0, 1);
    step(w[7], 28, 1, 1, 0, 1);
    step(NOP, 0, 0, 0, 1, 0);
    // out-of-range redirect finishes the run
    start = 1'b1;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0; redirect = 1'b1; redirect_pc = 32'd40;
    step(NOP, 0, 0, 0, 1, 0);
    redirect = 1'b0;
    step(NOP, 0, 0, 0, 1, 0);
`else
    // redirect ignored: strictly sequential
    prog_len = 7'd3; start = 1'b1;
    step(w[0], 0, 1, 1, 0, 1);
    start = 1'b0; redirect = 1'b1; redirect_pc = 32'd24;
    step(w[1], 4, 1, 1, 0, 1);
    redirect = 1'b0;
    step(w[2], 8, 1, 1, 0, 1);
    step(NOP, 0, 0, 0, 1, 0);
`endif

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expected outputs left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_issue.md
# instr_issue

Instruction issue unit driving the `instruction` input of the single-cycle `top` core. It holds a small loadable program buffer and, once started, presents one instruction per clock. It supplies the NOP fill (`addi zero, zero, 0`) whenever it is idle, stalled or finished, so the core's register file stays stable. It is the producer end of the instruction interface that `top` consumes.

## Interface
- `DEPTH`, 64: program buffer entries; power of two.
- `AW`, 6: index width, equal to log2(DEPTH).
- `NOP`, 32'h00000013: fill instruction.
- `clock`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — synchronous, active-high.
- `load_en`  in  1  — write `load_data` to `buf[load_addr]`; accepted only in IDLE or DONE.
- `load_addr`  in  AW  — write index.
- `load_data`  in  32  — instruction word.
- `prog_len`  in  AW+1  — number of instructions to issue, 0..DEPTH; sampled on `start`.
- `start`  in  1  — begin a run from index 0; honoured in IDLE or DONE.
- `stall`  in  1  — insert a bubble; the issue index holds.
- `redirect`  in  1  — jump request; ignored unless REDIRECT_EN.
- `redirect_pc`  in  32  — byte target; bits [AW+1:2] form the index, bits [1:0] are ignored.
- `instruction`  out  32  — registered instruction to the core.
- `pc`  out  32  — byte address (4×index) of the presented instruction.
- `valid`  out  1  — `instruction` is a program word, not fill.
- `busy`  out  1  — high in RUN.
- `done`  out  1  — high in DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Internal index `idx` is AW+1 bits wide. Stored length is `len`.
- Reset: state=IDLE, `instruction`=NOP, `pc`=0, `valid`=0, `busy`=0, `done`=0, `idx`=0. Buffer contents are not cleared.
- IDLE/DONE with `start`=1:
  - `prog_len`=0: go to DONE; outputs remain NOP.
  - Otherwise: `len`←`prog_len`, `instruction`←`buf[0]`, `pc`←0, `valid`←1, `idx`←1, state→RUN.
- IDLE/DONE, `start` and `load_en` both asserted: `start` wins; the load is dropped.
- RUN, per edge, in priority order:
  1. Redirect (only with REDIRECT_EN): `instruction`←NOP, `valid`←0. If target index < `len`, `idx`←target; otherwise state→DONE.
  2. `stall`: `instruction`←NOP, `valid`←0; `idx` and `pc` hold.
  3. `idx`==`len`: `instruction`←NOP, `valid`←0, state→DONE.
  4. Otherwise: `instruction`←`buf[idx]`, `pc`←4·`idx`, `valid`←1, `idx`←`idx`+1.
- Stall and redirect never lose or duplicate a program word. The word at `idx` is presented on the first unstalled edge.
- `load_en` during RUN is ignored.
- `start` during RUN is ignored.
- DONE outputs NOP continuously until `start` or `reset`.
- `busy` and `done` are registered and decoded from the next state.
- `prog_len` > DEPTH is clamped to DEPTH.

## Timing
- `start` to first instruction: 1 edge. `buf[0]` is visible immediately after the edge that samples `start`.
- Unstalled throughput: 1 instruction per cycle. A run of N words occupies N cycles of `valid`=1, then NOP follows.
- `done` rises on the edge after the last word has been presented for one cycle.
- Each stall cycle inserts exactly one NOP cycle.
- Each redirect inserts exactly one NOP cycle; the target word follows on the next edge.
- Reset mid-run: NOP, state IDLE, and all outputs at reset values after that edge.
- A load takes effect one edge after `load_en`. A load and a read of the same index in the same cycle are impossible, because loads are rejected during RUN.

## Configuration
- `INSTR_ISSUE_REDIRECT_EN` defined: `redirect`/`redirect_pc` are active as described above.
- Undefined: the ports remain but are ignored; behaviour is strictly sequential with stalls only, and no comparator logic is synthesised.

## Test plan
- Reset, then load 5 words (`addi a1..a5` encodings), `prog_len`=5, pulse `start`: `instruction` equals `buf[0..4]` on 5 consecutive cycles with `pc`=0,4,8,12,16 and `valid`=1; then NOP, `valid`=0, `done`=1.
- Stall for 2 cycles after the 2nd word: 2 NOP cycles with `valid`=0 and `pc` held at 4; then `buf[2]` at `pc`=8; `done` comes 2 cycles later than in the unstalled run.
- `prog_len`=0 with `start`: next edge `done`=1, `busy`=0, `instruction`=NOP throughout.
- Assert `load_en` to index 0 with 32'hDEADBEEF during RUN: `buf[0]` is unchanged on the next run.
- Assert `reset` during the 3rd word: next edge `instruction`=NOP, `pc`=0, `valid`=0, `busy`=0, `done`=0.
- With REDIRECT_EN, `prog_len`=8, redirect to `pc`=24 during word 1: one NOP, then `buf[6]`, `buf[7]`, then DONE. Redirect to `pc`=40: NOP and `done` on the next edge.
